// File: rtl/jpeg_ac_symbolizer_if.sv
// Coefficient-in / symbol-out bus for the JPEG run-length symbolizer.
// The slave modport is the symbolizer; the master modport is its environment.
interface jpeg_ac_symbolizer_if #(
  parameter int DATA_WIDTH = 11
);
  logic signed [DATA_WIDTH-1:0] coef_in;
  logic                         coef_valid_in;
  logic                         coef_ready_out;
  logic                         sym_valid_out;
  logic                         sym_ready_in;
  logic [3:0]                   sym_run_out;
  logic [3:0]                   sym_size_out;
  logic [DATA_WIDTH-1:0]        sym_amp_out;
  logic                         sym_is_dc_out;
  logic                         sym_eob_out;
  logic                         block_done_out;

  modport slave (
    input  coef_in, coef_valid_in, sym_ready_in,
    output coef_ready_out, sym_valid_out, sym_run_out, sym_size_out,
           sym_amp_out, sym_is_dc_out, sym_eob_out, block_done_out
  );

  modport master (
    output coef_in, coef_valid_in, sym_ready_in,
    input  coef_ready_out, sym_valid_out, sym_run_out, sym_size_out,
           sym_amp_out, sym_is_dc_out, sym_eob_out, block_done_out
  );
endinterface

// File: rtl/jpeg_ac_symbolizer.sv
// Zig-zag coefficients in, JPEG DC/AC/ZRL/EOB symbols out, one 8x8 block at a time.
// Optional macro JPEG_SYM_DC_PRED_EN enables differential DC coding with a frame-scoped predictor.
module jpeg_ac_symbolizer #(
  parameter int DATA_WIDTH = 11,
  parameter int BLOCK_LEN  = 64
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  frame_start_in,
  jpeg_ac_symbolizer_if.slave   bus
);

  localparam int IDX_W  = $clog2(BLOCK_LEN);
  localparam int DIFF_W = DATA_WIDTH + 1;
  localparam int ZRL_W  = IDX_W - 4;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_LEN - 1);

  typedef enum logic [1:0] {S_ACCEPT, S_ZRL, S_SYM} state_t;

  state_t                   r_state, w_next_state;
  logic [IDX_W-1:0]         r_idx;
  logic [IDX_W-1:0]         r_run;
  logic [ZRL_W-1:0]         r_zrl_left;

  logic                     r_valid;
  logic [3:0]               r_sym_run;
  logic [3:0]               r_sym_size;
  logic [DATA_WIDTH-1:0]    r_sym_amp;
  logic                     r_is_dc;
  logic                     r_eob;
  logic                     r_last;

  logic [3:0]               r_pend_run;
  logic [3:0]               r_pend_size;
  logic [DATA_WIDTH-1:0]    r_pend_amp;
  logic                     r_pend_last;

  logic                     w_accept;
  logic                     w_out_hs;
  logic                     w_is_dc;
  logic                     w_is_last;
  logic                     w_zero;
  logic [ZRL_W-1:0]         w_nzrl;
  logic signed [DIFF_W-1:0] w_coef_ext;
  logic signed [DIFF_W-1:0] w_dc_val;
  logic signed [DIFF_W-1:0] w_val;
  logic [3:0]               w_size;
  logic [DATA_WIDTH-1:0]    w_amp;

  logic                     w_ld;
  logic [3:0]               w_ld_run;
  logic [3:0]               w_ld_size;
  logic [DATA_WIDTH-1:0]    w_ld_amp;
  logic                     w_ld_dc;
  logic                     w_ld_eob;
  logic                     w_ld_last;
  logic                     w_pend_ld;

  function automatic logic [3:0] f_size(input logic signed [DIFF_W-1:0] v);
    logic [DIFF_W-1:0] mag;
    mag    = v[DIFF_W-1] ? -v : v;
    f_size = 4'd0;
    for (int i = 0; i < DIFF_W; i++)
      if (mag[i]) f_size = 4'(i + 1);
  endfunction

  // Negative values are sent as the one's complement of their magnitude.
  function automatic logic [DATA_WIDTH-1:0] f_amp(input logic signed [DIFF_W-1:0] v,
                                                  input logic [3:0] sz);
    logic [DIFF_W-1:0] t;
    logic [DIFF_W-1:0] mask;
    t     = v[DIFF_W-1] ? (v - DIFF_W'(1)) : v;
    mask  = (DIFF_W'(1) << sz) - DIFF_W'(1);
    f_amp = DATA_WIDTH'(t & mask);
  endfunction

  assign w_coef_ext = {bus.coef_in[DATA_WIDTH-1], bus.coef_in};

`ifdef JPEG_SYM_DC_PRED_EN
  logic signed [DATA_WIDTH-1:0] r_pred;
  logic signed [DATA_WIDTH-1:0] w_pred_eff;

  // A frame start coincident with the DC sample must already see a zero predictor.
  assign w_pred_eff = frame_start_in ? '0 : r_pred;
  assign w_dc_val   = w_coef_ext - {w_pred_eff[DATA_WIDTH-1], w_pred_eff};

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)                    r_pred <= '0;
    else if (w_accept && w_is_dc)  r_pred <= bus.coef_in;
    else if (frame_start_in)       r_pred <= '0;
  end
`else
  logic w_unused_frame_start;
  assign w_unused_frame_start = frame_start_in;
  assign w_dc_val             = w_coef_ext;
`endif

  assign w_out_hs           = r_valid && bus.sym_ready_in;
  assign bus.coef_ready_out = (r_state == S_ACCEPT) && (!r_valid || bus.sym_ready_in);
  assign w_accept           = bus.coef_valid_in && bus.coef_ready_out;
  assign w_is_dc            = (r_idx == '0);
  assign w_is_last          = (r_idx == LAST_IDX);
  assign w_zero             = (bus.coef_in == '0);
  assign w_nzrl             = r_run[IDX_W-1:4];
  assign w_val              = w_is_dc ? w_dc_val : w_coef_ext;
  assign w_size             = f_size(w_val);
  assign w_amp              = f_amp(w_val, w_size);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) r_state <= S_ACCEPT;
    else        r_state <= w_next_state;
  end

  // Long runs park the real AC symbol in the pending slot while ZRLs drain;
  // SYM means the last ZRL is on the output and the pending symbol goes next.
  always_comb begin
    w_next_state = r_state;
    w_ld         = 1'b0;
    w_ld_run     = 4'd0;
    w_ld_size    = 4'd0;
    w_ld_amp     = '0;
    w_ld_dc      = 1'b0;
    w_ld_eob     = 1'b0;
    w_ld_last    = 1'b0;
    w_pend_ld    = 1'b0;
    case (r_state)
      S_ACCEPT: begin
        if (w_accept) begin
          if (w_is_dc) begin
            w_ld      = 1'b1;
            w_ld_size = w_size;
            w_ld_amp  = w_amp;
            w_ld_dc   = 1'b1;
          end else if (!w_zero) begin
            w_ld = 1'b1;
            if (w_nzrl != '0) begin
              w_ld_run     = 4'hF;
              w_pend_ld    = 1'b1;
              w_next_state = (w_nzrl == ZRL_W'(1)) ? S_SYM : S_ZRL;
            end else begin
              w_ld_run  = r_run[3:0];
              w_ld_size = w_size;
              w_ld_amp  = w_amp;
              w_ld_last = w_is_last;
            end
          end else if (w_is_last) begin
            w_ld      = 1'b1;
            w_ld_eob  = 1'b1;
            w_ld_last = 1'b1;
          end
        end
      end
      S_ZRL: begin
        if (w_out_hs) begin
          w_ld     = 1'b1;
          w_ld_run = 4'hF;
          if (r_zrl_left == ZRL_W'(1)) w_next_state = S_SYM;
        end
      end
      S_SYM: begin
        if (w_out_hs) begin
          w_ld         = 1'b1;
          w_ld_run     = r_pend_run;
          w_ld_size    = r_pend_size;
          w_ld_amp     = r_pend_amp;
          w_ld_last    = r_pend_last;
          w_next_state = S_ACCEPT;
        end
      end
      default: w_next_state = S_ACCEPT;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_idx <= '0;
      r_run <= '0;
    end else if (w_accept) begin
      r_idx <= w_is_last ? '0 : r_idx + IDX_W'(1);
      r_run <= (!w_is_dc && w_zero && !w_is_last) ? r_run + IDX_W'(1) : '0;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_zrl_left  <= '0;
      r_pend_run  <= 4'd0;
      r_pend_size <= 4'd0;
      r_pend_amp  <= '0;
      r_pend_last <= 1'b0;
    end else if (w_pend_ld) begin
      r_zrl_left  <= w_nzrl - ZRL_W'(1);
      r_pend_run  <= r_run[3:0];
      r_pend_size <= w_size;
      r_pend_amp  <= w_amp;
      r_pend_last <= w_is_last;
    end else if (r_state == S_ZRL && w_out_hs) begin
      r_zrl_left  <= r_zrl_left - ZRL_W'(1);
    end
  end

  // The output register only reloads when empty or handing off, so a stalled symbol holds.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_valid    <= 1'b0;
      r_sym_run  <= 4'd0;
      r_sym_size <= 4'd0;
      r_sym_amp  <= '0;
      r_is_dc    <= 1'b0;
      r_eob      <= 1'b0;
      r_last     <= 1'b0;
    end else if (w_ld) begin
      r_valid    <= 1'b1;
      r_sym_run  <= w_ld_run;
      r_sym_size <= w_ld_size;
      r_sym_amp  <= w_ld_amp;
      r_is_dc    <= w_ld_dc;
      r_eob      <= w_ld_eob;
      r_last     <= w_ld_last;
    end else if (bus.sym_ready_in) begin
      r_valid    <= 1'b0;
    end
  end

  assign bus.sym_valid_out  = r_valid;
  assign bus.sym_run_out    = r_sym_run;
  assign bus.sym_size_out   = r_sym_size;
  assign bus.sym_amp_out    = r_sym_amp;
  assign bus.sym_is_dc_out  = r_is_dc;
  assign bus.sym_eob_out    = r_eob;
  assign bus.block_done_out = w_out_hs && r_last;

endmodule
